// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared state, tag and FP32 field definitions for the fp_add arbiter.
package fp_arb_pkg;
    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int FP_W   = SIGN_W + EXP_W + MAN_W;
    localparam int IDX_W  = 3;

    typedef enum logic {RUN, DRAIN} state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             byp;
        logic [FP_W-1:0]  byp_val;
    } tag_t;

    function automatic logic is_zero(input logic [FP_W-1:0] x);
        return x[EXP_W+MAN_W-1:0] == '0;
    endfunction
endpackage

// File: rtl/fp_rr_arbiter.sv
// fp_rr_arbiter: one-hot round-robin grant; ptr_i is the highest-priority index.
module fp_rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);
    logic             found;
    logic [IDX_W-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IDX_W'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one external fp_adder among NUM_REQ requesters.
// Define FP_ARB_ZERO_BYPASS_EN to return the non-zero operand directly when one input is +/-0.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                    clk_x70,
    input  logic                    rst_x70,
    input  logic [NUM_REQ-1:0]      req_valid_x70,
    input  logic [FP_W*NUM_REQ-1:0] req_a_x70,
    input  logic [FP_W*NUM_REQ-1:0] req_b_x70,
    output logic [NUM_REQ-1:0]      req_ready_x70,
    input  logic                    flush_x70,
    output logic                    idle_x70,
    output logic [FP_W-1:0]         add_a_x70,
    output logic [FP_W-1:0]         add_b_x70,
    input  logic [FP_W-1:0]         add_sum_x70,
    output logic [NUM_REQ-1:0]      resp_valid_x70,
    output logic [FP_W-1:0]         resp_sum_x70
);
    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, gnt_idx;
    logic [NUM_REQ-1:0]   arb_req, gnt;
    tag_t                 tag_q [0:ADD_LAT];
    tag_t                 tag_d;
    logic                 busy, xfer;
    logic [FP_W-1:0]      sel_a, sel_b, add_a_q, add_b_q, resp_sum_q;
    logic [NUM_REQ-1:0]   resp_valid_q;

    assign arb_req = (state_q == RUN && !flush_x70) ? req_valid_x70 : '0;
    assign xfer    = |gnt;

    fp_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= ADD_LAT; k++) busy = busy | tag_q[k].valid;
    end

    always_comb begin
        state_d = flush_x70 ? DRAIN : (state_q == DRAIN && busy) ? DRAIN : RUN;
        ptr_d   = !xfer ? ptr_q : (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        sel_a   = req_a_x70[FP_W*gnt_idx +: FP_W];
        sel_b   = req_b_x70[FP_W*gnt_idx +: FP_W];
        tag_d       = '0;
        tag_d.valid = xfer;
        tag_d.idx   = gnt_idx;
`ifdef FP_ARB_ZERO_BYPASS_EN
        tag_d.byp     = is_zero(sel_a) | is_zero(sel_b);
        tag_d.byp_val = is_zero(sel_b) ? sel_a : sel_b;
`else
        tag_d.byp     = 1'b0;
        tag_d.byp_val = '0;
`endif
    end

    // The last tag stage lines up with add_sum_x70 for the operation it describes.
    always_ff @(posedge clk_x70) begin
        if (rst_x70) begin
            state_q      <= RUN;
            ptr_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_valid_q <= '0;
            resp_sum_q   <= '0;
            for (int k = 0; k <= ADD_LAT; k++) tag_q[k] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (xfer) begin
                add_a_q <= sel_a;
                add_b_q <= sel_b;
            end
            tag_q[0] <= tag_d;
            for (int k = 1; k <= ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
            resp_valid_q <= tag_q[ADD_LAT].valid ? NUM_REQ'(1) << tag_q[ADD_LAT].idx : '0;
            resp_sum_q   <= !tag_q[ADD_LAT].valid ? '0 :
                            tag_q[ADD_LAT].byp ? tag_q[ADD_LAT].byp_val : add_sum_x70;
        end
    end

    assign req_ready_x70  = gnt;
    assign idle_x70       = state_q == RUN && !busy && !xfer;
    assign add_a_x70      = add_a_q;
    assign add_b_x70      = add_b_q;
    assign resp_valid_x70 = resp_valid_q;
    assign resp_sum_x70   = resp_sum_q;
endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one fp_adder instance (2..8).
REQ-002 Parameter ADD_LAT, default 1, fp_adder latency in clk_x70 cycles from operand drive to sum_x70 valid.
REQ-003 clk_x70  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_x70  input  1  reset, synchronous, active-high.
REQ-005 req_valid_x70  input  NUM_REQ  per-requester operand-pair valid.
REQ-006 req_a_x70  input  32*NUM_REQ  packed IEEE-754 single operand A, requester i at [32i+31:32i].
REQ-007 req_b_x70  input  32*NUM_REQ  packed operand B, same packing.
REQ-008 req_ready_x70  output  NUM_REQ  one-hot grant; transfer when valid and ready are both high.
REQ-009 flush_x70  input  1  level request to stop granting and drain the adder pipeline.
REQ-010 idle_x70  output  1  high when no operation is in flight and no flush is draining.
REQ-011 add_a_x70, add_b_x70  output  32 each  operands driven to fp_adder inp1_x70/inp2_x70.
REQ-012 add_sum_x70  input  32  fp_adder sum_x70.
REQ-013 resp_valid_x70  output  NUM_REQ  one-hot result strobe, one cycle, no backpressure.
REQ-014 resp_sum_x70  output  32  result for the requester flagged in resp_valid_x70.

Function
REQ-015 Grant is round-robin: search starts at the index after the last granted requester, wrapping from NUM_REQ-1 to 0.
REQ-016 At most one grant per cycle; req_ready_x70 is combinational from req_valid_x70, the RR pointer and FSM state.
REQ-017 Operands of the granted requester are registered into add_a_x70/add_b_x70 on the transfer edge.
REQ-018 A tag pipeline of depth ADD_LAT+1 carries {valid, requester index, bypass flag, bypass value} alongside each operation.
REQ-019 resp_valid_x70 bit i pulses exactly ADD_LAT+1 cycles after the transfer edge of requester i; throughput one result per cycle.
REQ-020 Results return in grant order; no reordering.
REQ-021 FSM states RUN and DRAIN; RUN->DRAIN when flush_x70=1; DRAIN->RUN when flush_x70=0 and the tag pipeline is empty.
REQ-022 In DRAIN req_ready_x70 is all zeros; in-flight operations still complete and respond.
REQ-023 flush_x70 asserted in the same cycle as a valid request: no grant that cycle.
REQ-024 RR pointer advances only on an actual transfer; it is not updated when no request is valid.
REQ-025 idle_x70 = (state==RUN) and tag pipeline empty and no transfer this cycle.

Reset
REQ-026 On rst_x70: state RUN, RR pointer 0 (requester 0 highest priority next), tag pipeline cleared.
REQ-027 Reset values: req_ready_x70 follows valid (combinational), resp_valid_x70 0, resp_sum_x70 0, add_a_x70 0, add_b_x70 0, idle_x70 1.
REQ-028 rst_x70 mid-operation discards all in-flight operations; no response is issued for them.

Configuration
REQ-029 Macro FP_ARB_ZERO_BYPASS_EN: when defined, an operand with exponent 0 and mantissa 0 (+/-0) sets the bypass flag, and the other operand (A if both are zero) is returned as resp_sum_x70 at the normal latency without using the adder result.
REQ-030 Without FP_ARB_ZERO_BYPASS_EN the bypass flag is tied to 0 and all results come from add_sum_x70.

Structure
REQ-031 Package fp_arb_pkg holds the state enum {RUN, DRAIN}, the tag struct, and the FP32 field-width constants (sign 1, exponent 8, mantissa 23).
REQ-032 One sub-module, fp_rr_arbiter (request vector and pointer in, one-hot grant out); fp_adder is instantiated outside this block.

Verification
REQ-033 Requester 0 sends 1.0+1.0 (0x3F800000, 0x3F800000) -> resp_valid_x70=4'b0001 with resp_sum_x70=0x40000000 two cycles after the transfer.
REQ-034 All four requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3 and responses in the same order, one per cycle.
REQ-035 flush_x70 held high for 3 cycles with two operations in flight -> no grants, both responses delivered, idle_x70=1 after the last response.
REQ-036 rst_x70 pulsed one cycle after a transfer -> no response for that operation, RR pointer 0, idle_x70=1.
REQ-037 With FP_ARB_ZERO_BYPASS_EN, requester 2 sends 0x00000000 + 0x40400000 -> resp_valid_x70=4'b0100 and resp_sum_x70=0x40400000 at latency 2. Without the macro, the same stimulus returns add_sum_x70 unchanged.
REQ-038 Only requester 3 valid, then requesters 0 and 3 valid -> requester 0 is granted first (wrap-around from pointer 3).
